// File: rtl/mdu_pkg.sv
// Shared definitions for the parametrised multiply/divide unit.
// Holds the op encodings, the latency-select helper and a small max helper.
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MFHI  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } mdu_op_e;

  // Busy-cycle count for an op; 0 means it completes at the accepting edge.
  function automatic int unsigned lat_sel(input logic [OP_W-1:0] op,
                                          input int unsigned mul_cycles,
                                          input int unsigned div_cycles);
    int unsigned lat;
    lat = 0;
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: lat = mul_cycles;
      OP_DIV, OP_DIVU:                                         lat = div_cycles;
      default:                                                 lat = 0;
    endcase
    return lat;
  endfunction

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for the MDU.
// Ports: op (operation), a/b (operands), hi/lo (current accumulator)
//        -> new_hi/new_lo (value HI/LO should take), write_en (HI/LO update).
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] new_hi,
  output logic [WIDTH-1:0] new_lo,
  output logic             write_en
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [W2-1:0] prod_s, prod_u, acc;

  // A 2W-wide product of sign-extended operands equals the signed product mod 2^2W.
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi, lo};

  logic             b_zero;
  logic [WIDTH-1:0] b_div, a_mag, b_mag;
  logic [WIDTH-1:0] q_u, r_u, q_m, r_m, q_s, r_s;

  // Divisor forced non-zero so the dividers never see 0; the result is dropped anyway.
  assign b_zero = (b == '0);
  assign b_div  = b_zero ? WIDTH'(1) : b;
  assign q_u    = a / b_div;
  assign r_u    = a % b_div;

  // Signed divide on magnitudes. MIN/-1 falls out as q=MIN, r=0 since -MIN wraps to MIN.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b_div[WIDTH-1] ? -b_div : b_div;
  assign q_m   = a_mag / b_mag;
  assign r_m   = a_mag % b_mag;
  assign q_s   = (a[WIDTH-1] ^ b_div[WIDTH-1]) ? -q_m : q_m;
  assign r_s   = a[WIDTH-1] ? -r_m : r_m;

  // Op decode into the new HI/LO pair.
  always_comb begin
    new_hi   = hi;
    new_lo   = lo;
    write_en = 1'b0;
    case (op)
      OP_MULT:  begin {new_hi, new_lo} = prod_s;       write_en = 1'b1; end
      OP_MULTU: begin {new_hi, new_lo} = prod_u;       write_en = 1'b1; end
      OP_MADD:  begin {new_hi, new_lo} = acc + prod_s; write_en = 1'b1; end
      OP_MADDU: begin {new_hi, new_lo} = acc + prod_u; write_en = 1'b1; end
      OP_MSUB:  begin {new_hi, new_lo} = acc - prod_s; write_en = 1'b1; end
      OP_MSUBU: begin {new_hi, new_lo} = acc - prod_u; write_en = 1'b1; end
      OP_DIV: begin
        new_hi   = r_s;
        new_lo   = q_s;
        write_en = !b_zero;
      end
      OP_DIVU: begin
        new_hi   = r_u;
        new_lo   = q_u;
        write_en = !b_zero;
      end
      OP_MTHI:  begin new_hi = a; write_en = 1'b1; end
      OP_MTLO:  begin new_lo = a; write_en = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_pipe_gen.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async active-low), start/op/in_a/in_b (E-stage issue),
//        req (exception taken in M; aborts a coinciding start),
//        busy (multi-cycle op in flight), hi_out/lo_out (HI/LO registers).
module mdu_pipe_gen
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned MAX_CYC = max_u(MUL_CYCLES, DIV_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_we;
  int unsigned      lat;

  // Result is computed from the HI/LO visible at the accepting edge.
  mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op      (op),
    .a       (in_a),
    .b       (in_b),
    .hi      (hi_q),
    .lo      (lo_q),
    .new_hi  (calc_hi),
    .new_lo  (calc_lo),
    .write_en(calc_we)
  );

  assign lat    = lat_sel(op, MUL_CYCLES, DIV_CYCLES);
  assign busy   = (state_q == ST_BUSY);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  // Handshake: accept when idle and not aborted; commit pending result as busy drops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !req) begin
          if (lat == 0) begin
            if (calc_we) begin
              hi_d = calc_hi;
              lo_d = calc_lo;
            end
          end else begin
            state_d   = ST_BUSY;
            cnt_d     = CNT_W'(lat);
            pend_hi_d = calc_hi;
            pend_lo_d = calc_lo;
            pend_we_d = calc_we;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_IDLE;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
